// File: rtl/ram_pkg.sv
// Shared types and defaults for the simple-dual-port byte-enable RAM family.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 7;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Bare storage array: one byte-enabled write port, one registered read port, no reset.
module ram_sdp_core #(
  parameter int DW = 32,
  parameter int AW = 7,
  parameter int BW = DW / 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wbe,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Read returns the pre-write word on a same-address collision; the top merges.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BW; b++) begin
      if (we && wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, write-first collision and a post-reset clear sweep.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int BE_WIDTH = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  function automatic logic [DATA_WIDTH-1:0] merge_be(input logic [DATA_WIDTH-1:0] old_w,
                                                     input logic [DATA_WIDTH-1:0] new_w,
                                                     input logic [BE_WIDTH-1:0]   be);
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  sweep_p0, rd_acc_p0, wr_acc_p0;
  logic                  core_we_p0;
  logic [ADDR_WIDTH-1:0] core_waddr_p0;
  logic [BE_WIDTH-1:0]   core_wbe_p0;
  logic [DATA_WIDTH-1:0] core_wdata_p0;
  logic [DATA_WIDTH-1:0] core_q_p1;
  logic                  coll_p1, rd_zero_p1;
  logic [BE_WIDTH-1:0]   be_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  // Port traffic is only honoured in READY and while reset is released.
  assign sweep_p0  = rst_n && (state == CLEAR);
  assign rd_acc_p0 = rst_n && (state == READY) && rd_en;
  assign wr_acc_p0 = rst_n && (state == READY) && wr_en;

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_cnt == '1) state_nx = READY;
  end

  always_comb begin
    core_we_p0    = wr_acc_p0;
    core_waddr_p0 = wr_addr;
    core_wbe_p0   = wr_be;
    core_wdata_p0 = wr_data;
    if (sweep_p0) begin
      core_we_p0    = 1'b1;
      core_waddr_p0 = clr_cnt;
      core_wbe_p0   = '1;
      core_wdata_p0 = INIT_VALUE;
    end
  end

  ram_sdp_core #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH),
    .BW(BE_WIDTH)
  ) u_core (
    .clk  (clk),
    .we   (core_we_p0),
    .waddr(core_waddr_p0),
    .wbe  (core_wbe_p0),
    .wdata(core_wdata_p0),
    .re   (rd_acc_p0),
    .raddr(rd_addr),
    .rdata(core_q_p1)
  );

  // ---- p0 -> p1 boundary: control and collision capture ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      init_busy  <= 1'b1;
      rd_valid   <= 1'b0;
      rd_zero_p1 <= 1'b1;
    end else begin
      state     <= state_nx;
      init_busy <= (state_nx == CLEAR);
      rd_valid  <= rd_acc_p0;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (rd_acc_p0) rd_zero_p1 <= 1'b0;
    end
  end

  // Collision side data is held with the read word so rd_data stays stable between reads.
  always_ff @(posedge clk) begin
    if (rd_acc_p0) begin
      coll_p1  <= wr_acc_p0 && (wr_addr == rd_addr);
      be_p1    <= wr_be;
      wdata_p1 <= wr_data;
    end
  end

  assign rd_data = rd_zero_p1 ? '0 :
                   coll_p1    ? merge_be(core_q_p1, wdata_p1, be_p1) : core_q_p1;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed self-checking bench for ram_sdp_be with default parameters.
module tb_ram_sdp_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_busy;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  int checks = 0;
  int errors = 0;

  ram_sdp_be dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_busy(init_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [6:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check(tag, rd_data, exp);
  endtask

  // Counts cycles until init_busy falls; optionally pokes ports at cycle 20.
  task automatic wait_sweep(input string tag, input bit poke, output int n);
    n = 0;
    while (init_busy && n < 300) begin
      if (poke && n == 20) begin
        rd_en = 1'b1; rd_addr = 7'd10;
        wr_en = 1'b1; wr_addr = 7'd10; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
      end
      tick();
      n++;
      if (poke && n == 21) begin
        rd_en = 1'b0; wr_en = 1'b0;
        check("clear_rd_valid", {31'd0, rd_valid}, 32'd0);
      end
    end
    check(tag, n, 128);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    check("rst_busy", {31'd0, init_busy}, 32'd1);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data", rd_data, 32'd0);
    rst_n = 1'b1;
    wait_sweep("sweep_len", 1'b0, n);

    check("idle_valid", {31'd0, rd_valid}, 32'd0);
    rd_check("init0", 7'd0, 32'd0);
    rd_check("init64", 7'd64, 32'd0);
    rd_check("init127", 7'd127, 32'd0);

    wr(7'd5, 32'hDEAD_BEEF, 4'hF);
    wr(7'd5, 32'h0000_00AA, 4'h1);
    rd_check("be_merge", 7'd5, 32'hDEAD_BEAA);

    wr(7'd9, 32'hAAAA_AAAA, 4'hF);
    wr_en = 1'b1; wr_addr = 7'd9; wr_data = 32'h1234_5678; wr_be = 4'hC;
    rd_en = 1'b1; rd_addr = 7'd9;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("coll_valid", {31'd0, rd_valid}, 32'd1);
    check("coll_data", rd_data, 32'h1234_AAAA);
    rd_check("coll_later", 7'd9, 32'h1234_AAAA);

    wr(7'd7, 32'h0BAD_F00D, 4'h0);
    rd_check("be_zero", 7'd7, 32'd0);

    wr(7'd126, 32'h1111_1111, 4'hF);
    wr(7'd127, 32'h2222_2222, 4'hF);
    wr(7'd0, 32'h3333_3333, 4'hF);
    rd_en = 1'b1; rd_addr = 7'd126;
    tick();
    check("b2b_v0", {31'd0, rd_valid}, 32'd1);
    check("b2b_d0", rd_data, 32'h1111_1111);
    rd_addr = 7'd127;
    tick();
    check("b2b_v1", {31'd0, rd_valid}, 32'd1);
    check("b2b_d1", rd_data, 32'h2222_2222);
    rd_addr = 7'd0;
    tick();
    check("b2b_v2", {31'd0, rd_valid}, 32'd1);
    check("b2b_d2", rd_data, 32'h3333_3333);
    rd_en = 1'b0;
    tick();
    check("hold_valid", {31'd0, rd_valid}, 32'd0);
    check("hold_data", rd_data, 32'h3333_3333);

    wr(7'd3, 32'h5555_5555, 4'hF);
    rd_check("pre_rst3", 7'd3, 32'h5555_5555);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("mid_busy", {31'd0, init_busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", {31'd0, init_busy}, 32'd1);
    check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
    wait_sweep("resweep_len", 1'b1, n);
    rd_check("post_rst3", 7'd3, 32'd0);
    rd_check("post_clr10", 7'd10, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
